// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed 7-segment display scanner.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package disp_pkg;

    localparam int PRESC_DEF = 50000;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 render as a single dash.
module bcd7seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_disp_scan.sv
// Multiplexed common-anode display scanner with per-frame snapshot
// and leading-zero blanking.
module bcd_disp_scan
    import disp_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int PRESC = PRESC_DEF
) (
    input  logic               clk,
    input  logic               Rn,
    input  logic               ce,
    input  logic [4*N_DIG-1:0] dat,
    input  logic [N_DIG-1:0]   dp,
    input  logic               blank_lz,
    output logic [N_DIG-1:0]   AN,
    output logic [6:0]         SEG,
    output logic               DP,
    output logic               tick
);

    localparam int CW = $clog2(PRESC);
    localparam int IW = $clog2(N_DIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [4*N_DIG-1:0] snap_dat_q, snap_dat_d;
    logic [N_DIG-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic [3:0]         digit;
    logic [6:0]         seg_dec;
    logic [N_DIG-1:0]   zero_from;
    logic               blank;

    assign digit = snap_dat_q[{idx_q, 2'b00} +: 4];

    bcd7seg u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    // zero_from[i]: every snapshot digit from i upward is zero
    always_comb begin
        zero_from = '0;
        for (int i = 0; i < N_DIG; i++) begin
            zero_from[i] = ~|(snap_dat_q >> (4 * i));
        end
    end

    assign blank = blank_lz && (idx_q != '0) && zero_from[idx_q];
    assign tick  = ce && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_dat_d = snap_dat_q;
        snap_dp_d  = snap_dp_q;
        an_d       = an_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        if (ce) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            an_d  = ~(N_DIG'(1) << idx_q);
            seg_d = blank ? SEG_OFF : seg_dec;
            dp_d  = ~snap_dp_q[idx_q];
        end
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
                snap_dat_d = dat;
                snap_dp_d  = dp;
            end
        end
    end

    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_dat_q <= '0;
            snap_dp_q  <= '0;
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_dat_q <= snap_dat_d;
            snap_dp_q  <= snap_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule
